fifo_unpacker: RTL and testbench

FIFO_UNPACKER -- requirements
Module: fifo_unpacker

---
 rtl/fifo_unpacker.sv | 89 ++++++++
 tb/tb_fifo_unpacker.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_unpacker.sv
// Reads one wide word from a FIFO and replays it as DATA_WIDTH/OUT_WIDTH narrow beats,
// least-significant slice first, with a ready/valid handshake on the output side.
module fifo_unpacker #(
  parameter int DATA_WIDTH = 128,
  parameter int OUT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  srst,
  input  logic                  fifo_mty,
  input  logic [DATA_WIDTH-1:0] fifo_q,
  output logic                  fifo_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam int BEATS = DATA_WIDTH / OUT_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SEND
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] hold;
  logic [OUT_WIDTH-1:0]  slices [BEATS];
  logic                  in_send;
  logic                  beat_xfer;

  for (genvar i = 0; i < BEATS; i++) begin : g_slice
    assign slices[i] = hold[i*OUT_WIDTH +: OUT_WIDTH];
  end

  assign in_send   = (state == SEND);
  assign out_valid = in_send;
  assign out_last  = in_send && (cnt == LAST_CNT);
  assign out_data  = in_send ? slices[cnt] : '0;
  assign busy      = (state != IDLE);
  assign beat_xfer = in_send && out_ready;

  // A new read is issued from IDLE, or as a prefetch while the last beat leaves.
  assign fifo_rd = arst_n && !srst && !fifo_mty &&
                   ((state == IDLE) || (beat_xfer && out_last));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
    end else if (srst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (fifo_rd) state_next = WAIT;
      WAIT: state_next = SEND;
      SEND: if (beat_xfer && out_last) state_next = fifo_rd ? WAIT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // fifo_q is only valid in WAIT, the cycle after the read strobe.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt  <= '0;
      hold <= '0;
    end else if (srst) begin
      cnt  <= '0;
      hold <= '0;
    end else if (state == WAIT) begin
      hold <= fifo_q;
      cnt  <= '0;
    end else if (beat_xfer) begin
      cnt <= out_last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_unpacker.sv
// Self-checking bench for fifo_unpacker: a behavioural FIFO feeds words, a scoreboard
// checks every accepted beat, and a vector table checks cycle-exact handshake timing.
module tb_fifo_unpacker;

  localparam logic [127:0] W1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] W2 = 128'h88888888_77777777_66666666_55555555;

  logic         clk = 1'b0;
  logic         arst_n;
  logic         srst;
  logic         fifo_mty;
  logic [127:0] fifo_q = '0;
  logic         fifo_rd;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_last;
  logic         busy;

  logic         force_mty;
  logic         mon_on = 1'b0;
  logic [127:0] mem [0:8191];
  int           wr_ptr = 0;
  int           rd_ptr = 0;
  int           compared = 0;
  int           mismatched = 0;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;
  beat_t exp_q[$];

  typedef struct {
    logic         push;
    logic [127:0] word;
    logic         ready;
    logic         exp_rd;
    logic         exp_valid;
    logic [31:0]  exp_data;
    logic         exp_last;
    logic         exp_busy;
  } vec_t;
  vec_t tbl[$];

  fifo_unpacker #(.DATA_WIDTH(128), .OUT_WIDTH(32)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .srst      (srst),
    .fifo_mty  (fifo_mty),
    .fifo_q    (fifo_q),
    .fifo_rd   (fifo_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  assign fifo_mty = force_mty || (rd_ptr == wr_ptr);

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [127:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  function automatic void addVec(input logic push, input logic [127:0] word, input logic ready,
                                 input logic rd, input logic v, input logic [31:0] d,
                                 input logic l, input logic b);
    vec_t r;
    r.push = push; r.word = word; r.ready = ready; r.exp_rd = rd;
    r.exp_valid = v; r.exp_data = d; r.exp_last = l; r.exp_busy = b;
    tbl.push_back(r);
  endfunction

  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    out_ready = v.ready;
    if (v.push) push_word(v.word);
  endtask

  // Behavioural FIFO: data appears the cycle after the read; every read queues its beats.
  always @(posedge clk) begin : fifo_model
    logic [127:0] w;
    if (!arst_n || srst) begin
      exp_q.delete();
    end else if (fifo_rd) begin
      w = mem[rd_ptr];
      fifo_q <= w;
      rd_ptr <= rd_ptr + 1;
      for (int i = 0; i < 4; i++) exp_q.push_back('{data: w[i*32 +: 32], last: (i == 3)});
    end
  end

  always @(negedge clk) begin : monitor
    beat_t e;
    if (mon_on) begin
      checkOutput("rd_while_mty", {127'b0, fifo_rd && fifo_mty}, 128'd0);
      if (out_valid && out_ready && !srst && arst_n) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_beat", {96'b0, out_data}, 128'hDEAD);
        end else begin
          e = exp_q.pop_front();
          checkOutput("sb_data", {96'b0, out_data}, {96'b0, e.data});
          checkOutput("sb_last", {127'b0, out_last}, {127'b0, e.last});
        end
      end
    end
  end

  initial begin
    int rd_cnt, beat_cnt, busy_cnt;
    arst_n = 1'b0; srst = 1'b0; out_ready = 1'b1; force_mty = 1'b0;
    push_word(W1);
    #1;
    checkOutput("reset_rd", {127'b0, fifo_rd}, 128'd0);
    checkOutput("reset_valid", {127'b0, out_valid}, 128'd0);
    checkOutput("reset_data", {96'b0, out_data}, 128'd0);
    checkOutput("reset_last", {127'b0, out_last}, 128'd0);
    checkOutput("reset_busy", {127'b0, busy}, 128'd0);
    wr_ptr = 0;
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;
    mon_on = 1'b1;

    // single word, then backpressure on beat 2 with a second word queued behind it
    addVec(1, W1, 1, 1, 0, 32'h0,        0, 0);
    addVec(0, 0,  1, 0, 0, 32'h0,        0, 1);
    addVec(0, 0,  1, 0, 1, 32'h11111111, 0, 1);
    addVec(0, 0,  1, 0, 1, 32'h22222222, 0, 1);
    addVec(0, 0,  1, 0, 1, 32'h33333333, 0, 1);
    addVec(0, 0,  1, 0, 1, 32'h44444444, 1, 1);
    addVec(0, 0,  1, 0, 0, 32'h0,        0, 0);
    addVec(1, W1, 1, 1, 0, 32'h0,        0, 0);
    addVec(1, W2, 1, 0, 0, 32'h0,        0, 1);
    addVec(0, 0,  1, 0, 1, 32'h11111111, 0, 1);
    for (int i = 0; i < 5; i++) addVec(0, 0, 0, 0, 1, 32'h22222222, 0, 1);
    addVec(0, 0,  1, 0, 1, 32'h22222222, 0, 1);
    addVec(0, 0,  1, 0, 1, 32'h33333333, 0, 1);
    addVec(0, 0,  1, 1, 1, 32'h44444444, 1, 1);
    addVec(0, 0,  1, 0, 0, 32'h0,        0, 1);
    addVec(0, 0,  1, 0, 1, 32'h55555555, 0, 1);
    addVec(0, 0,  1, 0, 1, 32'h66666666, 0, 1);
    addVec(0, 0,  1, 0, 1, 32'h77777777, 0, 1);
    addVec(0, 0,  1, 0, 1, 32'h88888888, 1, 1);
    addVec(0, 0,  1, 0, 0, 32'h0,        0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_rd", i), {127'b0, fifo_rd}, {127'b0, tbl[i].exp_rd});
      checkOutput($sformatf("vec%0d_valid", i), {127'b0, out_valid}, {127'b0, tbl[i].exp_valid});
      checkOutput($sformatf("vec%0d_data", i), {96'b0, out_data}, {96'b0, tbl[i].exp_data});
      checkOutput($sformatf("vec%0d_last", i), {127'b0, out_last}, {127'b0, tbl[i].exp_last});
      checkOutput($sformatf("vec%0d_busy", i), {127'b0, busy}, {127'b0, tbl[i].exp_busy});
    end

    // empty FIFO: nothing may happen
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("empty_rd", {127'b0, fifo_rd}, 128'd0);
      checkOutput("empty_busy", {127'b0, busy}, 128'd0);
    end

    // back-to-back: three words, one gap cycle between each
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) push_word({$urandom, $urandom, $urandom, $urandom});
    rd_cnt = 0; beat_cnt = 0; busy_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      rd_cnt += int'(fifo_rd);
      beat_cnt += int'(out_valid && out_ready);
      busy_cnt += int'(busy);
    end
    checkOutput("b2b_reads", rd_cnt, 128'd3);
    checkOutput("b2b_beats", beat_cnt, 128'd12);
    checkOutput("b2b_busy_cycles", busy_cnt, 128'd15);

    // srst while in WAIT: first word discarded, read held off during srst
    @(posedge clk); #1; push_word(W1); push_word(W2);
    @(negedge clk); checkOutput("srst_pre_rd", {127'b0, fifo_rd}, 128'd1);
    @(posedge clk); #1; srst = 1'b1;
    @(negedge clk); checkOutput("srst_wait_rd", {127'b0, fifo_rd}, 128'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("srst_busy", {127'b0, busy}, 128'd0);
    checkOutput("srst_valid", {127'b0, out_valid}, 128'd0);
    checkOutput("srst_rd_held", {127'b0, fifo_rd}, 128'd0);
    @(posedge clk); #1; srst = 1'b0;
    @(negedge clk); checkOutput("srst_after_rd", {127'b0, fifo_rd}, 128'd1);
    repeat (8) @(posedge clk);
    #1;
    checkOutput("srst_drained", exp_q.size(), 128'd0);

    // async reset in the middle of SEND
    @(posedge clk); #1; push_word(W1);
    @(posedge clk); #1; push_word(W2);
    @(posedge clk);
    @(posedge clk); #2;
    arst_n = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("arst_valid", {127'b0, out_valid}, 128'd0);
    checkOutput("arst_data", {96'b0, out_data}, 128'd0);
    checkOutput("arst_last", {127'b0, out_last}, 128'd0);
    checkOutput("arst_busy", {127'b0, busy}, 128'd0);
    checkOutput("arst_rd", {127'b0, fifo_rd}, 128'd0);
    @(posedge clk); #1; arst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("arst_drained", exp_q.size(), 128'd0);

    // random empty flag and backpressure
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
      force_mty = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 2) == 0 && wr_ptr < 8100)
        push_word({$urandom, $urandom, $urandom, $urandom});
    end
    @(posedge clk); #1;
    force_mty = 1'b1;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("random_drained", exp_q.size(), 128'd0);
    checkOutput("random_idle", {127'b0, busy}, 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
